pixel_row_packer: RTL and testbench

PIXEL_ROW_PACKER -- requirements
Module: pixel_row_packer

---
 rtl/pixel_row_packer_if.sv | 25 ++
 rtl/pixel_row_packer.sv | 106 ++++++++++
 tb/tb_pixel_row_packer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_row_packer_if.sv
// Pixel-in / packed-row-out handshake bundle for pixel_row_packer.
// slave = the packer, master = the upstream/downstream driver.
interface pixel_row_packer_if #(
  parameter int W         = 24,
  parameter int DATA_BITS = 8
);
  logic                   pix_valid_i;
  logic [DATA_BITS-1:0]   pix_data_i;
  logic                   pix_ready_o;
  logic                   row_valid_o;
  logic [W*DATA_BITS-1:0] row_data_o;
  logic                   row_ready_i;
  logic                   row_last_o;
  logic                   frame_done_o;

  modport slave (
    input  pix_valid_i, pix_data_i, row_ready_i,
    output pix_ready_o, row_valid_o, row_data_o, row_last_o, frame_done_o
  );

  modport master (
    output pix_valid_i, pix_data_i, row_ready_i,
    input  pix_ready_o, row_valid_o, row_data_o, row_last_o, frame_done_o
  );
endinterface

// File: rtl/pixel_row_packer.sv
// Packs a pixel stream into W-pixel rows (first pixel at MSB) with one row of
// accumulation plus one output register, and flags frame boundaries every H rows.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | output register empty, accumulator filling
// ST_OUT   | output register holds a row, accumulator filling
// ST_BOTH  | output register holds a row, accumulator holds a full row (stall)
module pixel_row_packer #(
  parameter int W         = 24,
  parameter int H         = 24,
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              resetn,
  pixel_row_packer_if.slave bus
);
  localparam int ROW_BITS = W * DATA_BITS;
  localparam int COL_W    = (W > 1) ? $clog2(W) : 1;
  localparam int ROWC_W   = (H > 1) ? $clog2(H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(W - 1);
  localparam logic [ROWC_W-1:0] ROW_LAST = ROWC_W'(H - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_OUT   = 2'b01,
    ST_BOTH  = 2'b11
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROWC_W-1:0]   row_q, row_d;
  logic [ROW_BITS-1:0] acc_q, acc_d, out_q;
  logic                last_q, frame_done_q;
  logic                pix_fire, row_fire, out_free, row_done, last_ld;

  assign pix_fire = bus.pix_valid_i && (state_q != ST_BOTH);
  assign row_fire = (state_q != ST_EMPTY) && bus.row_ready_i;
  assign out_free = (state_q == ST_EMPTY) || bus.row_ready_i;
  assign row_done = pix_fire && (col_q == COL_LAST);

  // Shifting in at the LSB leaves pixel 0 at the MSB once W pixels are in.
  generate
    if (W == 1) begin : g_acc_single
      assign acc_d = pix_fire ? bus.pix_data_i : acc_q;
    end else begin : g_acc_shift
      assign acc_d = pix_fire ? {acc_q[ROW_BITS-DATA_BITS-1:0], bus.pix_data_i} : acc_q;
    end
  endgenerate

  // A row loaded at an edge sits behind every row transferred up to that edge.
  assign row_d   = row_fire ? ((row_q == ROW_LAST) ? '0 : row_q + 1'b1) : row_q;
  assign last_ld = (row_d == ROW_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_EMPTY;
      col_q        <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      row_q        <= row_d;
      frame_done_q <= row_fire && last_q;
      if (pix_fire) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      case (state_q)
        ST_EMPTY: begin
          if (row_done) begin
            out_q   <= acc_d;
            last_q  <= last_ld;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (row_done && out_free) begin
            out_q   <= acc_d;
            last_q  <= last_ld;
          end else if (row_done) begin
            state_q <= ST_BOTH;
          end else if (row_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_BOTH: begin
          if (out_free) begin
            out_q   <= acc_q;
            last_q  <= last_ld;
            state_q <= ST_OUT;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.pix_ready_o  = (state_q != ST_BOTH);
  assign bus.row_valid_o  = (state_q != ST_EMPTY);
  assign bus.row_data_o   = out_q;
  assign bus.row_last_o   = last_q;
  assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_pixel_row_packer.sv
// Directed and randomized bench for pixel_row_packer with a row scoreboard.
module tb_pixel_row_packer;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 8;
  localparam int RB = W * DB;
  localparam int LIMIT = 200;

  logic clk;
  logic resetn;

  pixel_row_packer_if #(.W(W), .DATA_BITS(DB)) bus ();

  pixel_row_packer #(.W(W), .H(H), .DATA_BITS(DB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic          last;
    logic [RB-1:0] data;
  } row_t;

  row_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   rows_xfer = 0;
  int   lasts = 0;
  int   fd_pulses = 0;
  int   pix_acc = 0;
  int   stalls = 0;
  bit   rand_mode = 0;

  int            mcol = 0;
  int            mrow = 0;
  logic [RB-1:0] macc = '0;
  bit            hold = 0;
  logic [RB-1:0] hold_data = '0;
  logic          hold_last = 0;
  logic          fd_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] make_row(input int base);
    logic [RB-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r[(W-k)*DB-1 -: DB] = 8'(base + k);
    return r;
  endfunction

  // Scoreboard: rows pushed as the bench's pixels are accepted, popped on row transfer.
  always @(negedge clk) begin
    row_t e;
    logic pf, rf;
    if (!resetn) begin
      q.delete();
      mcol = 0;
      mrow = 0;
      hold = 0;
      fd_exp = 0;
    end else begin
      chk("frame_done", RB'(bus.frame_done_o), RB'(fd_exp));
      if (bus.frame_done_o === 1'b1) fd_pulses++;
      if (hold) begin
        chk("hold_valid", RB'(bus.row_valid_o), RB'(1'b1));
        chk("hold_data", bus.row_data_o, hold_data);
        chk("hold_last", RB'(bus.row_last_o), RB'(hold_last));
      end
      pf = bus.pix_valid_i && bus.pix_ready_o;
      rf = bus.row_valid_o && bus.row_ready_i;
      if (rf) begin
        rows_xfer++;
        if (bus.row_last_o === 1'b1) lasts++;
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL row_extra observed=unexpected row %0h expected=no row", bus.row_data_o);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("row_data", bus.row_data_o, e.data);
          chk("row_last", RB'(bus.row_last_o), RB'(e.last));
        end
      end
      if (pf) begin
        pix_acc++;
        macc[(W-mcol)*DB-1 -: DB] = bus.pix_data_i;
        if (mcol == W - 1) begin
          e.last = (mrow == H - 1);
          e.data = macc;
          q.push_back(e);
          mrow = (mrow + 1) % H;
          mcol = 0;
        end else begin
          mcol++;
        end
      end
      fd_exp    = rf && bus.row_last_o;
      hold      = bus.row_valid_o && !bus.row_ready_i;
      hold_data = bus.row_data_o;
      hold_last = bus.row_last_o;
    end
  end

  task automatic rand_rdy();
    if (rand_mode) bus.row_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_pix(input logic [DB-1:0] d);
    int n;
    n = 0;
    if (rand_mode) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.pix_valid_i = 1'b0;
        bus.pix_data_i  = 8'($urandom);
        rand_rdy();
        @(posedge clk); #1;
      end
    end
    bus.pix_valid_i = 1'b1;
    bus.pix_data_i  = d;
    forever begin
      rand_rdy();
      @(negedge clk);
      if (bus.pix_ready_o) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      stalls++;
      n++;
      if (n >= LIMIT) begin
        checks++;
        errors++;
        $error("FAIL pix_timeout observed=no accept in %0d cycles expected=accept", n);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.pix_valid_i = 1'b0;
    repeat (n) begin
      rand_rdy();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    bus.pix_valid_i = 1'b0;
    bus.row_ready_i = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int r0, l0, f0, s0, p0;
    bus.pix_valid_i = 1'b0;
    bus.pix_data_i  = '0;
    bus.row_ready_i = 1'b0;
    resetn = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_row_valid", RB'(bus.row_valid_o), '0);
    chk("rst_row_data", bus.row_data_o, '0);
    chk("rst_row_last", RB'(bus.row_last_o), '0);
    chk("rst_frame_done", RB'(bus.frame_done_o), '0);
    chk("rst_pix_ready", RB'(bus.pix_ready_o), RB'(1'b1));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // First row, consumer always ready
    bus.row_ready_i = 1'b1;
    for (int i = 0; i < W; i++) drive_pix(8'(i));
    bus.pix_valid_i = 1'b0;
    chk("r031_valid", RB'(bus.row_valid_o), RB'(1'b1));
    chk("r031_msb", RB'(bus.row_data_o[RB-1 -: DB]), RB'(8'h00));
    chk("r031_lsb", RB'(bus.row_data_o[DB-1:0]), RB'(8'h17));
    chk("r031_row", bus.row_data_o, make_row(0));
    chk("r031_last", RB'(bus.row_last_o), '0);
    idle(3);

    // Backpressure: two rows in with consumer stalled
    do_reset();
    for (int i = 0; i < 2 * W; i++) drive_pix(8'(i));
    chk("r032_ready_low", RB'(bus.pix_ready_o), '0);
    chk("r032_valid", RB'(bus.row_valid_o), RB'(1'b1));
    chk("r032_first_row", bus.row_data_o, make_row(0));
    for (int i = 0; i < 5; i++) begin
      bus.pix_valid_i = 1'b1;
      bus.pix_data_i  = 8'($urandom);
      @(negedge clk);
      chk("r036_ready_low", RB'(bus.pix_ready_o), '0);
      chk("r036_row_held", bus.row_data_o, make_row(0));
      @(posedge clk); #1;
    end
    bus.pix_valid_i = 1'b0;
    bus.row_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("r032_second_valid", RB'(bus.row_valid_o), RB'(1'b1));
    chk("r032_second_row", bus.row_data_o, make_row(W));
    chk("r032_ready_back", RB'(bus.pix_ready_o), RB'(1'b1));
    for (int i = 2 * W; i < 3 * W; i++) drive_pix(8'(i));
    idle(4);
    chk("r032_drained", RB'(q.size()), '0);
    chk("r032_rows", RB'(rows_xfer), RB'(4));

    // Two back-to-back frames at full rate
    do_reset();
    bus.row_ready_i = 1'b1;
    r0 = rows_xfer; l0 = lasts; f0 = fd_pulses; s0 = stalls;
    for (int i = 0; i < 2 * W * H; i++) drive_pix(8'(i));
    idle(4);
    chk("r033_rows", RB'(rows_xfer - r0), RB'(2 * H));
    chk("r033_lasts", RB'(lasts - l0), RB'(2));
    chk("r033_fd_pulses", RB'(fd_pulses - f0), RB'(2));
    chk("r033_no_stall", RB'(stalls - s0), '0);
    chk("r033_drained", RB'(q.size()), '0);

    // Random valid/ready over three frames
    do_reset();
    r0 = rows_xfer; l0 = lasts; p0 = pix_acc;
    rand_mode = 1;
    for (int i = 0; i < 3 * W * H; i++) drive_pix(8'($urandom));
    rand_mode = 0;
    bus.row_ready_i = 1'b1;
    idle(6);
    chk("r034_rows", RB'(rows_xfer - r0), RB'(3 * H));
    chk("r034_lasts", RB'(lasts - l0), RB'(3));
    chk("r034_pixels", RB'(pix_acc - p0), RB'(3 * W * H));
    chk("r034_drained", RB'(q.size()), '0);

    // Reset in the middle of row 5
    do_reset();
    bus.row_ready_i = 1'b1;
    for (int i = 0; i < 5 * W; i++) drive_pix(8'(i));
    bus.row_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) drive_pix(8'(150 + i));
    bus.pix_valid_i = 1'b0;
    chk("r035_pre_valid", RB'(bus.row_valid_o), RB'(1'b1));
    resetn = 1'b0;
    #1;
    chk("r035_valid_zero", RB'(bus.row_valid_o), '0);
    chk("r035_data_zero", bus.row_data_o, '0);
    chk("r035_last_zero", RB'(bus.row_last_o), '0);
    chk("r035_ready", RB'(bus.pix_ready_o), RB'(1'b1));
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.row_ready_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < W; i++) drive_pix(8'(200 + i));
    bus.pix_valid_i = 1'b0;
    chk("r035_row0_valid", RB'(bus.row_valid_o), RB'(1'b1));
    chk("r035_row0_data", bus.row_data_o, make_row(200));
    chk("r035_row0_last", RB'(bus.row_last_o), '0);
    idle(4);
    chk("r035_drained", RB'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
